bus_arbiter_nm: RTL and testbench

BUS_ARBITER_NM -- requirements
Module: bus_arbiter_nm

---
 rtl/bus_arbiter_nm.sv | 178 +++++++++++++++++
 tb/tb_bus_arbiter_nm.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_nm.sv
// Multi-master bus arbiter: round-robin grant, split parking with priority return, and a BUSY timeout.
// Latency: a request sampled in IDLE gives m_grant two cycles later (IDLE -> ARB -> BUSY).
// Backpressure: none. A master holds its request until granted. Parked split masters wait for their slave.
// Ports: sys_clk/sys_rst (async active-low); m_request/m_slave_sel in; trans_done, s_split_en in;
//        m_grant/bus_grant/slave_sel drive the bus mux; bus_busy, arbiter_busy, split_pending, timeout_err status.
module bus_arbiter_nm #(
    parameter int NUM_MASTERS = 2,
    parameter int NUM_SLAVES  = 3,
    parameter int SEL_W       = 2,
    parameter int MIDX_W      = 1,
    parameter int TIMEOUT     = 255
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst,
    input  logic [NUM_MASTERS-1:0]       m_request,
    input  logic [NUM_MASTERS*SEL_W-1:0] m_slave_sel,
    input  logic                         trans_done,
    input  logic [NUM_SLAVES-1:0]        s_split_en,
    output logic [NUM_MASTERS-1:0]       m_grant,
    output logic [MIDX_W-1:0]            bus_grant,
    output logic [SEL_W-1:0]             slave_sel,
    output logic                         bus_busy,
    output logic                         arbiter_busy,
    output logic [NUM_MASTERS-1:0]       split_pending,
    output logic                         timeout_err
);

    typedef enum logic [1:0] {IDLE, ARB, BUSY} state_t;

    state_t            state;
    logic [MIDX_W-1:0] last_grant;
    logic [MIDX_W-1:0] win_q;
    logic [SEL_W-1:0]  split_slave [NUM_MASTERS];
    logic [15:0]       tmo_cnt;

    logic [NUM_MASTERS-1:0] split_clear;
    logic [NUM_MASTERS-1:0] elig;
    logic [NUM_MASTERS-1:0] sp_ready;
    logic                   win_found;
    logic [MIDX_W-1:0]      win_idx;
    int                     best_dist;
    logic [NUM_MASTERS-1:0] win_onehot;
    logic [SEL_W-1:0]       win_sel;
    logic                   gnt_req;
    logic                   split_hit;
    logic                   tmo_hit;

    // A parked master becomes eligible again once its stored slave drops its split request.
    always_comb begin
        split_clear = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            for (int j = 0; j < NUM_SLAVES; j++) begin
                if (split_slave[i] == SEL_W'(j) && !s_split_en[j]) begin
                    split_clear[i] = 1'b1;
                end
            end
        end
    end

    // A parked master must still be requesting to be granted.
    assign elig     = m_request & (~split_pending | split_clear);
    assign sp_ready = elig & split_pending;

    // Returning split masters win (lowest index first); otherwise round-robin
    // by distance from last_grant+1, smallest distance wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        best_dist = NUM_MASTERS;
        if (|sp_ready) begin
            win_found = 1'b1;
            for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
                if (sp_ready[i]) begin
                    win_idx = MIDX_W'(i);
                end
            end
        end else begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (elig[i] && ((i + NUM_MASTERS - 1 - int'(last_grant)) % NUM_MASTERS) < best_dist) begin
                    best_dist = (i + NUM_MASTERS - 1 - int'(last_grant)) % NUM_MASTERS;
                    win_idx   = MIDX_W'(i);
                    win_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        win_onehot = '0;
        win_sel    = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (win_q == MIDX_W'(i)) begin
                win_onehot[i] = 1'b1;
                win_sel       = m_slave_sel[i*SEL_W +: SEL_W];
            end
        end
    end

    always_comb begin
        split_hit = 1'b0;
        for (int j = 0; j < NUM_SLAVES; j++) begin
            if (slave_sel == SEL_W'(j) && s_split_en[j]) begin
                split_hit = 1'b1;
            end
        end
    end

    assign gnt_req = |(m_grant & m_request);
    assign tmo_hit = (tmo_cnt == 16'(TIMEOUT - 1));

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state         <= IDLE;
            m_grant       <= '0;
            bus_grant     <= '0;
            slave_sel     <= '0;
            bus_busy      <= 1'b0;
            arbiter_busy  <= 1'b0;
            split_pending <= '0;
            timeout_err   <= 1'b0;
            last_grant    <= MIDX_W'(NUM_MASTERS - 1);
            win_q         <= '0;
            tmo_cnt       <= '0;
            for (int i = 0; i < NUM_MASTERS; i++) begin
                split_slave[i] <= '0;
            end
        end else begin
            arbiter_busy <= 1'b0;
            timeout_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        state        <= ARB;
                        win_q        <= win_idx;
                        arbiter_busy <= 1'b1;
                    end
                end
                ARB: begin
                    state         <= BUSY;
                    m_grant       <= win_onehot;
                    bus_grant     <= win_q;
                    slave_sel     <= win_sel;
                    bus_busy      <= 1'b1;
                    split_pending <= split_pending & ~win_onehot;
                    tmo_cnt       <= '0;
                end
                BUSY: begin
                    if (trans_done || !gnt_req || split_hit || tmo_hit) begin
                        state      <= IDLE;
                        m_grant    <= '0;
                        bus_grant  <= '0;
                        slave_sel  <= '0;
                        bus_busy   <= 1'b0;
                        last_grant <= bus_grant;
                        // Normal completion (done or request withdrawn) outranks a split,
                        // and a split outranks the timeout.
                        if (!trans_done && gnt_req) begin
                            if (split_hit) begin
                                split_pending <= split_pending | m_grant;
                                for (int i = 0; i < NUM_MASTERS; i++) begin
                                    if (m_grant[i]) begin
                                        split_slave[i] <= slave_sel;
                                    end
                                end
                            end else begin
                                timeout_err <= 1'b1;
                            end
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter_nm.sv
// Bench for bus_arbiter_nm: directed scenarios on three parameterisations plus randomized
// traffic on the default instance against a transaction-level reference model.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at that same point.
module tb_bus_arbiter_nm;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    // Instance A: defaults
    logic [1:0] a_req;   logic [3:0] a_sel;   logic a_done; logic [2:0] a_split;
    logic [1:0] a_gnt;   logic       a_bg;    logic [1:0] a_ss; logic a_bb; logic a_ab;
    logic [1:0] a_sp;    logic       a_te;
    // Instance B: TIMEOUT = 4
    logic [1:0] b_req;   logic [3:0] b_sel;   logic b_done; logic [2:0] b_split;
    logic [1:0] b_gnt;   logic       b_bg;    logic [1:0] b_ss; logic b_bb; logic b_ab;
    logic [1:0] b_sp;    logic       b_te;
    // Instance C: 4 masters, 5 slaves
    logic [3:0]  c_req;  logic [11:0] c_sel;  logic c_done; logic [4:0] c_split;
    logic [3:0]  c_gnt;  logic [1:0]  c_bg;   logic [2:0] c_ss; logic c_bb; logic c_ab;
    logic [3:0]  c_sp;   logic        c_te;

    bus_arbiter_nm #(.NUM_MASTERS(2), .NUM_SLAVES(3), .SEL_W(2), .MIDX_W(1), .TIMEOUT(255)) u_a (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .m_request(a_req), .m_slave_sel(a_sel),
        .trans_done(a_done), .s_split_en(a_split), .m_grant(a_gnt), .bus_grant(a_bg),
        .slave_sel(a_ss), .bus_busy(a_bb), .arbiter_busy(a_ab), .split_pending(a_sp),
        .timeout_err(a_te));

    bus_arbiter_nm #(.NUM_MASTERS(2), .NUM_SLAVES(3), .SEL_W(2), .MIDX_W(1), .TIMEOUT(4)) u_b (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .m_request(b_req), .m_slave_sel(b_sel),
        .trans_done(b_done), .s_split_en(b_split), .m_grant(b_gnt), .bus_grant(b_bg),
        .slave_sel(b_ss), .bus_busy(b_bb), .arbiter_busy(b_ab), .split_pending(b_sp),
        .timeout_err(b_te));

    bus_arbiter_nm #(.NUM_MASTERS(4), .NUM_SLAVES(5), .SEL_W(3), .MIDX_W(2), .TIMEOUT(255)) u_c (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .m_request(c_req), .m_slave_sel(c_sel),
        .trans_done(c_done), .s_split_en(c_split), .m_grant(c_gnt), .bus_grant(c_bg),
        .slave_sel(c_ss), .bus_busy(c_bb), .arbiter_busy(c_ab), .split_pending(c_sp),
        .timeout_err(c_te));

    // ---------------- reference model for instance A ----------------
    localparam int TMO_A = 255;
    int   md_owner;   // granted master, -1 when the bus is free
    int   md_cand;    // master chosen and waiting one cycle for its grant, -1 if none
    int   md_last;
    int   md_sel;
    int   md_busy;    // cycles the current owner has held the bus so far
    bit   md_terr;
    bit   md_sp [2];
    int   md_sps [2];

    task automatic model_reset();
        md_owner = -1; md_cand = -1; md_last = 1; md_sel = 0; md_busy = 0; md_terr = 0;
        for (int m = 0; m < 2; m++) begin md_sp[m] = 0; md_sps[m] = 0; end
    endtask

    // Advance the model over one clock edge using the inputs present at that edge.
    task automatic model_step();
        bit rel;
        rel = 0;
        md_terr = 0;
        if (md_owner >= 0) begin
            if (a_done || !a_req[md_owner]) rel = 1;
            else if (a_split[md_sel]) begin md_sp[md_owner] = 1; md_sps[md_owner] = md_sel; rel = 1; end
            else if (md_busy == TMO_A) begin rel = 1; md_terr = 1; end
            else md_busy++;
            if (rel) begin md_last = md_owner; md_owner = -1; md_sel = 0; end
        end else if (md_cand >= 0) begin
            md_owner = md_cand;
            md_sel = int'(a_sel[md_cand*2 +: 2]);
            md_sp[md_cand] = 0;
            md_busy = 1;
            md_cand = -1;
        end else begin
            for (int m = 0; m < 2; m++)
                if (md_cand < 0 && md_sp[m] && a_req[m] && !a_split[md_sps[m]]) md_cand = m;
            for (int k = 1; k <= 2; k++) begin
                int m;
                m = (md_last + k) % 2;
                if (md_cand < 0 && a_req[m] && !md_sp[m]) md_cand = m;
            end
        end
    endtask

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        a_req = '0; a_sel = '0; a_done = 0; a_split = '0;
        b_req = '0; b_sel = '0; b_done = 0; b_split = '0;
        c_req = '0; c_sel = '0; c_done = 0; c_split = '0;
        sys_rst = 0;
        #12;
        @(negedge sys_clk);
        sys_rst = 1;
        tick();
    endtask

    task automatic wait_grant(input int inst, input logic [3:0] exp, input string name);
        logic [3:0] cur;
        bit seen;
        seen = 0;
        cur = '0;
        for (int n = 0; n < 8 && !seen; n++) begin
            tick();
            cur = (inst == 0) ? {2'b00, a_gnt} : (inst == 1) ? {2'b00, b_gnt} : c_gnt;
            if (cur != 4'b0) seen = 1;
        end
        checks++;
        if (!seen || cur !== exp) begin
            errors++;
            $display("FAIL %s: grant got %b required %b (seen=%0d)", name, cur, exp, seen);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        checks++;
        if ({a_gnt, a_bg, a_ss, a_bb, a_ab, a_sp, a_te} !== 10'b0) begin
            errors++; $display("FAIL reset_a: outputs got %b required 0", {a_gnt, a_bg, a_ss, a_bb, a_ab, a_sp, a_te});
        end
        checks++;
        if ({c_gnt, c_bg, c_ss, c_bb, c_ab, c_sp, c_te} !== 16'b0) begin
            errors++; $display("FAIL reset_c: outputs got %b required 0", {c_gnt, c_bg, c_ss, c_bb, c_ab, c_sp, c_te});
        end
    endtask

    task automatic test_single_request();
        do_reset();
        a_req = 2'b01; a_sel = 4'b0010;
        tick();
        checks++;
        if (a_ab !== 1'b1 || a_gnt !== 2'b00) begin
            errors++; $display("FAIL single_arb: arbiter_busy=%b grant=%b required 1/00", a_ab, a_gnt);
        end
        tick();
        checks++;
        if (a_gnt !== 2'b01 || a_bg !== 1'b0 || a_ss !== 2'd2 || a_bb !== 1'b1 || a_ab !== 1'b0) begin
            errors++; $display("FAIL single_grant: gnt=%b bg=%b ss=%0d bb=%b ab=%b required 01/0/2/1/0",
                               a_gnt, a_bg, a_ss, a_bb, a_ab);
        end
        a_sel = 4'b0001;
        tick();
        checks++;
        if (a_ss !== 2'd2 || a_gnt !== 2'b01) begin
            errors++; $display("FAIL single_sel_stable: ss=%0d gnt=%b required 2/01", a_ss, a_gnt);
        end
        a_done = 1;
        tick();
        a_done = 0;
        checks++;
        if (a_gnt !== 2'b00 || a_bb !== 1'b0 || a_te !== 1'b0) begin
            errors++; $display("FAIL single_done: gnt=%b bb=%b te=%b required 00/0/0", a_gnt, a_bb, a_te);
        end
        a_req = 2'b00;
        tick();
        checks++;
        if (a_ab !== 1'b0 || a_gnt !== 2'b00) begin
            errors++; $display("FAIL idle_no_req: ab=%b gnt=%b required 0/00", a_ab, a_gnt);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_seq [4];
        exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0001; exp_seq[3] = 4'b0010;
        do_reset();
        a_req = 2'b11;
        for (int n = 0; n < 4; n++) begin
            wait_grant(0, exp_seq[n], "round_robin");
            repeat (3) tick();
            a_done = 1;
            tick();
            a_done = 0;
            checks++;
            if (a_gnt !== 2'b00) begin
                errors++; $display("FAIL rr_release: gnt=%b required 00 (n=%0d)", a_gnt, n);
            end
        end
        a_req = 2'b00;
    endtask

    task automatic test_split();
        do_reset();
        a_req = 2'b11; a_sel = 4'b0001;   // M0 -> slave 1, M1 -> slave 0
        wait_grant(0, 4'b0001, "split_first");
        a_split = 3'b010;
        tick();
        checks++;
        if (a_sp !== 2'b01 || a_gnt !== 2'b00) begin
            errors++; $display("FAIL split_park: sp=%b gnt=%b required 01/00", a_sp, a_gnt);
        end
        wait_grant(0, 4'b0010, "split_other");
        checks++;
        if (a_sp !== 2'b01 || a_ss !== 2'd0) begin
            errors++; $display("FAIL split_other_state: sp=%b ss=%0d required 01/0", a_sp, a_ss);
        end
        a_done = 1; a_split = 3'b000;
        tick();
        a_done = 0;
        wait_grant(0, 4'b0001, "split_return");
        checks++;
        if (a_sp !== 2'b00 || a_ss !== 2'd1) begin
            errors++; $display("FAIL split_clear: sp=%b ss=%0d required 00/1", a_sp, a_ss);
        end
        a_req = 2'b00;
    endtask

    task automatic test_simultaneous();
        do_reset();
        a_req = 2'b01; a_sel = 4'b0001;
        wait_grant(0, 4'b0001, "simul_grant");
        a_done = 1; a_split = 3'b010;
        tick();
        a_done = 0; a_split = 3'b000;
        checks++;
        if (a_sp !== 2'b00 || a_gnt !== 2'b00) begin
            errors++; $display("FAIL simul_done_split: sp=%b gnt=%b required 00/00", a_sp, a_gnt);
        end
        wait_grant(0, 4'b0001, "drop_grant");
        a_req = 2'b00;
        tick();
        checks++;
        if (a_gnt !== 2'b00 || a_sp !== 2'b00 || a_te !== 1'b0) begin
            errors++; $display("FAIL request_drop: gnt=%b sp=%b te=%b required 00/00/0", a_gnt, a_sp, a_te);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        b_req = 2'b01;
        wait_grant(1, 4'b0001, "timeout_grant");
        for (int n = 2; n <= 4; n++) begin
            tick();
            checks++;
            if (b_gnt !== 2'b01 || b_te !== 1'b0) begin
                errors++; $display("FAIL timeout_hold: cycle %0d gnt=%b te=%b required 01/0", n, b_gnt, b_te);
            end
        end
        tick();
        checks++;
        if (b_gnt !== 2'b00 || b_te !== 1'b1 || b_bb !== 1'b0) begin
            errors++; $display("FAIL timeout_release: gnt=%b te=%b bb=%b required 00/1/0", b_gnt, b_te, b_bb);
        end
        b_req = 2'b00;
        tick();
        checks++;
        if (b_te !== 1'b0) begin
            errors++; $display("FAIL timeout_pulse_width: te=%b required 0", b_te);
        end
    endtask

    task automatic test_reset_mid_busy();
        do_reset();
        a_req = 2'b01; a_sel = 4'b0010; b_req = 2'b01;
        tick(); tick();
        tick(); tick(); tick();   // B now in its last BUSY cycle before timeout
        #2;
        sys_rst = 0;
        #1;
        checks++;
        if ({a_gnt, a_bg, a_ss, a_bb, a_ab, a_sp, a_te} !== 10'b0) begin
            errors++; $display("FAIL reset_mid_busy_a: outputs got %b required 0", {a_gnt, a_bg, a_ss, a_bb, a_ab, a_sp, a_te});
        end
        checks++;
        if (b_gnt !== 2'b00 || b_bb !== 1'b0) begin
            errors++; $display("FAIL reset_mid_busy_b: gnt=%b bb=%b required 00/0", b_gnt, b_bb);
        end
        a_req = 2'b00; b_req = 2'b00;
        @(negedge sys_clk);
        sys_rst = 1;
        for (int n = 0; n < 2; n++) begin
            tick();
            checks++;
            if (b_te !== 1'b0) begin
                errors++; $display("FAIL reset_no_timeout: te=%b required 0 (n=%0d)", b_te, n);
            end
        end
    endtask

    task automatic test_four_masters();
        do_reset();
        c_sel = {3'd5, 3'd0, 3'd3, 3'd0};
        c_req = 4'b0010;
        wait_grant(2, 4'b0010, "nm4_first");
        c_done = 1;
        tick();
        c_done = 0;
        c_req = 4'b1011;
        checks++;
        if (c_gnt !== 4'b0000) begin
            errors++; $display("FAIL nm4_release: gnt=%b required 0000", c_gnt);
        end
        wait_grant(2, 4'b1000, "nm4_rr");
        checks++;
        if (c_bg !== 2'd3 || c_ss !== 3'd5) begin
            errors++; $display("FAIL nm4_index: bg=%0d ss=%0d required 3/5", c_bg, c_ss);
        end
        c_req = 4'b0000;
    endtask

    task automatic test_random();
        logic [1:0] e_gnt; logic e_bg; logic [1:0] e_ss; logic e_bb; logic e_ab; logic [1:0] e_sp; logic e_te;
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            if ($urandom_range(0, 5) == 0) a_req = 2'($urandom);
            a_sel   = {2'($urandom_range(0, 2)), 2'($urandom_range(0, 2))};
            a_done  = ($urandom_range(0, 7) == 0);
            a_split = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'b000;
            tick();
            model_step();
            e_gnt = (md_owner >= 0) ? 2'(1 << md_owner) : 2'b00;
            e_bg  = (md_owner == 1);
            e_ss  = 2'(md_sel);
            e_bb  = (md_owner >= 0);
            e_ab  = (md_cand >= 0);
            e_sp  = {md_sp[1], md_sp[0]};
            e_te  = md_terr;
            checks++;
            if (a_gnt !== e_gnt || a_bg !== e_bg || a_ss !== e_ss || a_bb !== e_bb) begin
                errors++; $display("FAIL random_grant: cycle %0d gnt/bg/ss/bb got %b/%b/%0d/%b required %b/%b/%0d/%b",
                                   cyc, a_gnt, a_bg, a_ss, a_bb, e_gnt, e_bg, e_ss, e_bb);
            end
            checks++;
            if (a_ab !== e_ab || a_sp !== e_sp || a_te !== e_te) begin
                errors++; $display("FAIL random_status: cycle %0d ab/sp/te got %b/%b/%b required %b/%b/%b",
                                   cyc, a_ab, a_sp, a_te, e_ab, e_sp, e_te);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_request();
        test_round_robin();
        test_split();
        test_simultaneous();
        test_timeout();
        test_reset_mid_busy();
        test_four_masters();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
